readout_sequencer: RTL and testbench
====================================

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning idle cycles allowed per channel before it is skipped.
REQ-002 SHALL have parameter NUM_CHAN, default 5, meaning channels read per fill, fixed to match the 5-bit go/done buses.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port fill_valid, input, 1, fill-number FIFO (first-word-fall-through) non-empty.
REQ-006 SHALL have port fill_num, input, 24, FIFO head: trigger number written by the trigger manager.
REQ-007 SHALL have port fill_rd, output, 1, one-cycle FIFO pop strobe.
REQ-008 SHALL have port chan_sel, output, 3, index of the channel being read (0..4).
REQ-009 SHALL have port chan_valid, input, 1, selected channel data word valid.
REQ-010 SHALL have port chan_data, input, 32, selected channel data word.
REQ-011 SHALL have port chan_last, input, 1, marks the final word of the selected channel.
REQ-012 SHALL have port chan_ready, output, 1, word accepted when chan_valid && chan_ready.
REQ-013 SHALL have port tx_valid, output, 1, output stream word valid.
REQ-014 SHALL have port tx_data, output, 32, output stream word.
REQ-015 SHALL have port tx_last, output, 1, marks the trailer word.
REQ-016 SHALL have port tx_ready, input, 1, downstream accepts when tx_valid && tx_ready.
REQ-017 SHALL have port chan_readout_done, output, 1, one-cycle pulse when the event is fully sent; drives the trigger manager input of the same name.

Function
REQ-018 SHALL implement states IDLE, POP, HEADER, STREAM, NEXT_CHAN, TRAILER and DONE.
REQ-019 IDLE: SHALL go to POP when fill_valid=1; otherwise SHALL hold.
REQ-020 POP: SHALL assert fill_rd for exactly one cycle, latch fill_num, clear word_count and err_mask, set chan_sel=0, then go to HEADER.
REQ-021 HEADER: SHALL present tx_data={8'hA5, fill_num}, tx_last=0, and go to STREAM on handshake.
REQ-022 The tx output register SHALL hold data/last stable while tx_valid && !tx_ready; tx_valid SHALL never drop without a handshake.
REQ-023 STREAM: chan_ready SHALL be 1 iff (!tx_valid || tx_ready); each accepted word SHALL load tx_data=chan_data, tx_last=0, tx_valid=1 on the next edge.
REQ-024 STREAM: word_count (16-bit, wraps 16'hFFFF->0) SHALL increment per accepted channel word.
REQ-025 STREAM: an accepted word with chan_last=1 SHALL exit to NEXT_CHAN.
REQ-026 STREAM: the timeout counter SHALL clear on entry and on every accepted word and increment otherwise.
REQ-027 STREAM timeout: on reaching TIMEOUT_CYCLES with no word, SHALL set err_mask[chan_sel] and go to NEXT_CHAN.
REQ-028 NEXT_CHAN: if chan_sel==NUM_CHAN-1, SHALL go to TRAILER; else SHALL increment chan_sel and return to STREAM. Lasts 1 cycle, chan_ready=0.
REQ-029 TRAILER: SHALL present tx_data={8'h5A, 3'b000, err_mask[4:0], word_count[15:0]}, tx_last=1, issued only when the output register is free; go to DONE after handshake.
REQ-030 DONE: SHALL pulse chan_readout_done for exactly one cycle, then return to IDLE.
REQ-031 chan_ready SHALL be 0 and fill_rd SHALL be 0 in every state other than STREAM and POP respectively.
REQ-032 A new fill SHALL NOT be popped before the prior event's chan_readout_done pulse.
REQ-033 chan_valid arriving with chan_last on the same cycle the timeout expires SHALL be accepted; the word takes priority over the timeout.

Reset
REQ-034 On reset=1 at a clock edge, SHALL enter IDLE from any state, including mid-event.
REQ-035 Reset SHALL force tx_valid=0, tx_last=0, tx_data=0, fill_rd=0, chan_ready=0, chan_readout_done=0, chan_sel=0, and word_count, err_mask and the timeout counter to 0.
REQ-036 A partially sent event SHALL be abandoned on reset, with no trailer emitted.

Structure
REQ-037 Header/trailer marker constants (8'hA5, 8'h5A) and the state encoding SHALL reside in shared package readout_pkg.
REQ-038 Output register/skid logic SHALL be one sub-module, stream_out_reg; everything else stays flat.

Verification
REQ-039 fill_num=24'h000001; channels give 2,1,3,1,1 words; tx_ready=1 -> header A5000001, 8 data words in channel order, trailer 5A000008, one done pulse.
REQ-040 Same as REQ-039 with tx_ready toggling 1/0 every cycle -> identical word sequence, no drop or duplicate, tx_data stable while stalled.
REQ-041 Channel 2 never asserts chan_valid, TIMEOUT_CYCLES=16 -> chan_sel advances after 16 idle cycles, trailer err_mask=5'b00100.
REQ-042 Two fills (5, 6) queued back-to-back -> second header A5000006 only after the first done pulse; fill_rd pulses exactly twice.
REQ-043 Reset asserted during STREAM of channel 3 -> next cycle tx_valid=0 and state IDLE; a later fill produces a clean event with word_count counted from 0.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared constants and state encoding for the fill readout sequencer.
// The trailer layout lives here so the sequencer and anything decoding its stream agree.
package readout_pkg;

   localparam logic [7:0] HDR_MARK = 8'hA5;
   localparam logic [7:0] TRL_MARK = 8'h5A;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_POP       = 3'd1,
      ST_HEADER    = 3'd2,
      ST_STREAM    = 3'd3,
      ST_NEXT_CHAN = 3'd4,
      ST_TRAILER   = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   function automatic logic [31:0] trailer_word(input logic [4:0]  err_mask,
                                                input logic [15:0] word_count);
      return {TRL_MARK, 3'b000, err_mask, word_count};
   endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry output register for the tx stream: a word loads only while the slot is
// free, so data/last stay frozen for as long as the downstream stalls.
module stream_out_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic        load_last,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   output logic        tx_last,
   output logic        free
);

   logic        valid_q, valid_d;
   logic [31:0] data_q, data_d;
   logic        last_q, last_d;

   // Free when empty or when the current word hands off this cycle.
   assign free = !valid_q || tx_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         last_d  = load_last;
      end else if (valid_q && tx_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign tx_valid = valid_q;
   assign tx_data  = data_q;
   assign tx_last  = last_q;

endmodule

// File: rtl/readout_sequencer.sv
// Pops one fill number, streams a header, every channel's words in order, and a trailer
// carrying the timeout error mask and word count, then pulses chan_readout_done.
module readout_sequencer
   import readout_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int NUM_CHAN       = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fill_valid,
   input  logic [23:0] fill_num,
   output logic        fill_rd,
   output logic [2:0]  chan_sel,
   input  logic        chan_valid,
   input  logic [31:0] chan_data,
   input  logic        chan_last,
   output logic        chan_ready,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   output logic        tx_last,
   input  logic        tx_ready,
   output logic        chan_readout_done,
   output state_t      dbg_state
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]       LAST_CHAN = 3'(NUM_CHAN - 1);

   state_t           state_q, state_d;
   logic [23:0]      fill_q, fill_d;
   logic [15:0]      wc_q, wc_d;
   logic [4:0]       err_q, err_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [2:0]       chan_sel_q, chan_sel_d;
   logic             issued_q, issued_d;

   logic        load;
   logic [31:0] load_data;
   logic        load_last;
   logic        out_free;
   logic        chan_accept;

   // Both ports use valid/ready: a word moves on any edge where valid && ready, the
   // source holds valid and payload steady until then, and ready may depend on valid.
   assign chan_ready  = (state_q == ST_STREAM) && out_free;
   assign chan_accept = chan_ready && chan_valid;

   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      wc_d       = wc_q;
      err_d      = err_q;
      tmo_d      = '0;
      chan_sel_d = chan_sel_q;
      issued_d   = issued_q;
      load       = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fill_valid) state_d = ST_POP;
         end
         ST_POP: begin
            fill_d     = fill_num;
            wc_d       = '0;
            err_d      = '0;
            chan_sel_d = '0;
            issued_d   = 1'b0;
            state_d    = ST_HEADER;
         end
         ST_HEADER: begin
            if (!issued_q) begin
               if (out_free) begin
                  load      = 1'b1;
                  load_data = {HDR_MARK, fill_q};
                  issued_d  = 1'b1;
               end
            end else if (tx_valid && tx_ready) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            // A word arriving on the expiry cycle wins over the timeout.
            if (chan_accept) begin
               load      = 1'b1;
               load_data = chan_data;
               wc_d      = wc_q + 16'd1;
               if (chan_last) state_d = ST_NEXT_CHAN;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = err_q | (5'd1 << chan_sel_q);
               state_d = ST_NEXT_CHAN;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_NEXT_CHAN: begin
            if (chan_sel_q == LAST_CHAN) begin
               issued_d = 1'b0;
               state_d  = ST_TRAILER;
            end else begin
               chan_sel_d = chan_sel_q + 3'd1;
               state_d    = ST_STREAM;
            end
         end
         ST_TRAILER: begin
            if (!issued_q) begin
               if (out_free) begin
                  load      = 1'b1;
                  load_data = trailer_word(err_q, wc_q);
                  load_last = 1'b1;
                  issued_d  = 1'b1;
               end
            end else if (tx_valid && tx_ready) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fill_q     <= '0;
         wc_q       <= '0;
         err_q      <= '0;
         tmo_q      <= '0;
         chan_sel_q <= '0;
         issued_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         wc_q       <= wc_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
         chan_sel_q <= chan_sel_d;
         issued_q   <= issued_d;
      end
   end

   stream_out_reg u_out (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .tx_ready  (tx_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_last   (tx_last),
      .free      (out_free)
   );

   assign fill_rd           = (state_q == ST_POP);
   assign chan_readout_done = (state_q == ST_DONE);
   assign chan_sel          = chan_sel_q;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: a FIFO and channel source model drive the DUT,
// and every tx handshake is checked against hand-computed words in exp_q.
module tb_readout_sequencer;
   import readout_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fill_valid, fill_rd;
   logic [23:0] fill_num;
   logic [2:0]  chan_sel;
   logic        chan_valid, chan_last, chan_ready;
   logic [31:0] chan_data;
   logic        tx_valid, tx_last, tx_ready;
   logic [31:0] tx_data;
   logic        chan_readout_done;
   state_t      dbg_state;

   int          total = 0;
   int          bad = 0;
   logic [32:0] exp_q[$];
   logic [23:0] fq[$];
   int          cnt[5];
   int          ptr = 0;
   logic [2:0]  last_sel = 3'd0;
   logic [23:0] cur_fill = '0;
   int          rdy_mode = 0;
   bit          rdy_phase = 1'b0;
   bit          sb_on = 1'b1;
   bit          saw_trl = 1'b0;
   int          fill_rd_cnt = 0;
   int          done_cnt = 0;
   int          sel2_cycles = 0;
   int          hdr6_done = -1;
   bit          pend_pop = 1'b0;
   bit          pend_chan = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   // clock / reset
   always #5 clk = ~clk;

   readout_sequencer #(.TIMEOUT_CYCLES(16), .NUM_CHAN(5)) dut (
      .clk               (clk),
      .reset             (reset),
      .fill_valid        (fill_valid),
      .fill_num          (fill_num),
      .fill_rd           (fill_rd),
      .chan_sel          (chan_sel),
      .chan_valid        (chan_valid),
      .chan_data         (chan_data),
      .chan_last         (chan_last),
      .chan_ready        (chan_ready),
      .tx_valid          (tx_valid),
      .tx_data           (tx_data),
      .tx_last           (tx_last),
      .tx_ready          (tx_ready),
      .chan_readout_done (chan_readout_done),
      .dbg_state         (dbg_state)
   );

   // Inputs change on negedge; handshakes are sampled 1 time unit before posedge.
   initial begin
      logic [23:0] dummy;
      logic [32:0] e;
      fill_valid = 1'b0;
      fill_num   = '0;
      chan_valid = 1'b0;
      chan_data  = '0;
      chan_last  = 1'b0;
      tx_ready   = 1'b1;
      forever begin
         @(negedge clk);
         if (pend_pop) begin
            dummy    = fq.pop_front();
            pend_pop = 1'b0;
            ptr      = 0;
         end
         if (pend_chan) ptr++;
         pend_chan = 1'b0;
         if (chan_sel !== last_sel || reset) ptr = 0;
         last_sel   = chan_sel;
         fill_valid = (fq.size() > 0);
         fill_num   = fill_valid ? fq[0] : 24'h0;
         tx_ready   = (rdy_mode == 0) ? 1'b1 : rdy_phase;
         rdy_phase  = ~rdy_phase;
         if (chan_sel < 3'd5 && ptr < cnt[chan_sel]) begin
            chan_valid = 1'b1;
            chan_data  = {8'hD0, cur_fill[7:0], 5'b0, chan_sel, 8'(ptr)};
            chan_last  = (ptr == cnt[chan_sel] - 1);
         end else begin
            chan_valid = 1'b0;
            chan_data  = '0;
            chan_last  = 1'b0;
         end
         #4;
         if (tx_valid && tx_ready) begin
            if (sb_on) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL tx_word got=%h last=%b want=none", tx_data, tx_last);
               end else begin
                  e = exp_q.pop_front();
                  if ({tx_last, tx_data} !== e) begin
                     bad++;
                     $display("FAIL tx_word got=%h last=%b want=%h last=%b",
                              tx_data, tx_last, e[31:0], e[32]);
                  end
               end
            end else if (tx_last) begin
               saw_trl = 1'b1;
            end
            if (tx_data == 32'hA5000006) hdr6_done = done_cnt;
         end
         if (prev_stall) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
               bad++;
               $display("FAIL tx_hold got=%b/%h/%b want=1/%h/%b",
                        tx_valid, tx_data, tx_last, prev_data, prev_last);
            end
         end
         prev_stall = tx_valid && !tx_ready && !reset;
         prev_data  = tx_data;
         prev_last  = tx_last;
         pend_chan  = chan_valid && chan_ready;
         if (fill_rd) begin
            fill_rd_cnt++;
            pend_pop = 1'b1;
            cur_fill = fill_num;
         end
         if (chan_readout_done) done_cnt++;
         if (chan_sel == 3'd2) sel2_cycles++;
      end
   end

   // driver tasks
   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push_data(input logic [7:0] f8);
      for (int c = 0; c < 5; c++)
         for (int i = 0; i < cnt[c]; i++)
            exp_q.push_back({1'b0, 8'hD0, f8, 5'b0, 3'(c), 8'(i)});
   endtask

   task automatic wait_done(input int target, output bit ok);
      int n = 0;
      while (done_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      ok = (done_cnt >= target);
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total += 8;
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid); end
      if (tx_data !== 32'h0) begin bad++; $display("FAIL rst_tx_data got=%h want=0", tx_data); end
      if (tx_last !== 1'b0) begin bad++; $display("FAIL rst_tx_last got=%b want=0", tx_last); end
      if (fill_rd !== 1'b0) begin bad++; $display("FAIL rst_fill_rd got=%b want=0", fill_rd); end
      if (chan_ready !== 1'b0) begin bad++; $display("FAIL rst_chan_ready got=%b want=0", chan_ready); end
      if (chan_readout_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", chan_readout_done); end
      if (chan_sel !== 3'd0) begin bad++; $display("FAIL rst_chan_sel got=%0d want=0", chan_sel); end
      if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_basic(input int mode, input string tag);
      int base, fr;
      bit ok;
      rdy_mode = mode;
      cnt = '{2, 1, 3, 1, 1};
      exp_q.push_back({1'b0, 32'hA5000001});
      push_data(8'h01);
      exp_q.push_back({1'b1, 32'h5A000008});
      base = done_cnt;
      fr   = fill_rd_cnt;
      fq.push_back(24'h000001);
      wait_done(base + 1, ok);
      total += 4;
      if (!ok) begin bad++; $display("FAIL %s_done_wait got=%0d want=%0d", tag, done_cnt, base + 1); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL %s_words_left got=%0d want=0", tag, exp_q.size()); end
      if (done_cnt != base + 1) begin bad++; $display("FAIL %s_done_pulses got=%0d want=1", tag, done_cnt - base); end
      if (fill_rd_cnt != fr + 1) begin bad++; $display("FAIL %s_fill_rd got=%0d want=1", tag, fill_rd_cnt - fr); end
      exp_q.delete();
      rdy_mode = 0;
   endtask

   task automatic test_timeout();
      int base;
      bit ok;
      cnt = '{2, 1, 0, 1, 1};
      exp_q.push_back({1'b0, 32'hA5000003});
      push_data(8'h03);
      exp_q.push_back({1'b1, 32'h5A040005});
      sel2_cycles = 0;
      base = done_cnt;
      fq.push_back(24'h000003);
      wait_done(base + 1, ok);
      total += 3;
      if (!ok) begin bad++; $display("FAIL tmo_done_wait got=%0d want=%0d", done_cnt, base + 1); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL tmo_words_left got=%0d want=0", exp_q.size()); end
      // 16 idle STREAM cycles plus the NEXT_CHAN cycle on channel 2
      if (sel2_cycles != 17) begin bad++; $display("FAIL tmo_sel2_cycles got=%0d want=17", sel2_cycles); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int base, fr;
      bit ok;
      cnt = '{1, 1, 1, 1, 1};
      exp_q.push_back({1'b0, 32'hA5000005});
      push_data(8'h05);
      exp_q.push_back({1'b1, 32'h5A000005});
      exp_q.push_back({1'b0, 32'hA5000006});
      push_data(8'h06);
      exp_q.push_back({1'b1, 32'h5A000005});
      base = done_cnt;
      fr   = fill_rd_cnt;
      hdr6_done = -1;
      fq.push_back(24'h000005);
      fq.push_back(24'h000006);
      wait_done(base + 2, ok);
      total += 4;
      if (!ok) begin bad++; $display("FAIL b2b_done_wait got=%0d want=%0d", done_cnt, base + 2); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_words_left got=%0d want=0", exp_q.size()); end
      if (fill_rd_cnt != fr + 2) begin bad++; $display("FAIL b2b_fill_rd got=%0d want=2", fill_rd_cnt - fr); end
      if (hdr6_done != base + 1) begin bad++; $display("FAIL b2b_hdr6_after_done got=%0d want=%0d", hdr6_done, base + 1); end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int base, n;
      bit ok;
      cnt = '{1, 1, 1, 20, 1};
      sb_on   = 1'b0;
      saw_trl = 1'b0;
      base = done_cnt;
      fq.push_back(24'h000007);
      n = 0;
      while (!(chan_sel == 3'd3 && dbg_state == ST_STREAM) && n < 500) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 500) begin bad++; $display("FAIL mid_reach_ch3 got=%0d want=3", chan_sel); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      total += 3;
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_tx_valid got=%b want=0", tx_valid); end
      if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL mid_state got=%0d want=%0d", dbg_state, ST_IDLE); end
      if (chan_ready !== 1'b0) begin bad++; $display("FAIL mid_chan_ready got=%b want=0", chan_ready); end
      repeat (30) @(negedge clk);
      total += 2;
      if (saw_trl) begin bad++; $display("FAIL mid_trailer got=1 want=0"); end
      if (done_cnt != base) begin bad++; $display("FAIL mid_done got=%0d want=0", done_cnt - base); end
      sb_on = 1'b1;
      cnt = '{1, 1, 1, 1, 1};
      exp_q.push_back({1'b0, 32'hA5000008});
      push_data(8'h08);
      exp_q.push_back({1'b1, 32'h5A000005});
      fq.push_back(24'h000008);
      wait_done(base + 1, ok);
      total += 2;
      if (!ok) begin bad++; $display("FAIL mid_done_wait got=%0d want=%0d", done_cnt, base + 1); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL mid_words_left got=%0d want=0", exp_q.size()); end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic(0, "basic");
      test_basic(1, "stall");
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
